// File: rtl/pump_drain_controller.sv
// pump_drain_controller: sequences one drain cycle, stepping water_level down by pump_speed per tick
// until SAFE_LEVEL, with pause/resume, abort, speed selection and a registered level alarm.
module pump_drain_controller #(
    parameter int         TICK_DIV    = 50_000_000,
    parameter logic [3:0] SAFE_LEVEL  = 4'd6,
    parameter logic [3:0] ALARM_LEVEL = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       speed_step,
    input  logic [3:0] level_in,
    output logic [3:0] water_level,
    output logic [1:0] pump_speed,
    output logic       pump_on,
    output logic       busy,
    output logic       done,
    output logic       alarm,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE, DRAIN, PAUSE, DONE} state_t;
    localparam int CW = $clog2(TICK_DIV);

    state_t          cur, nxt;
    logic [CW-1:0]   cnt;
    logic            tick;
    logic [4:0]      diff;
    logic [3:0]      nxt_level;

    assign tick  = cur == DRAIN && cnt == CW'(TICK_DIV - 1);
    assign diff  = {1'b0, water_level} - {1'b0, SAFE_LEVEL};
    assign state = cur;

    // A step that would land at or below the safe level clamps to it and finishes.
    always_comb begin
        nxt       = cur;
        nxt_level = water_level;
        case (cur)
            IDLE: if (start) begin
                nxt_level = level_in;
                nxt       = level_in > SAFE_LEVEL ? DRAIN : DONE;
            end
            DRAIN: if (abort) nxt = IDLE;
                else if (start) nxt = PAUSE;
                else if (tick) begin
                    if (!diff[4] && diff > {3'b0, pump_speed}) nxt_level = water_level - {2'b0, pump_speed};
                    else begin
                        nxt_level = SAFE_LEVEL;
                        nxt       = DONE;
                    end
                end
            PAUSE: if (abort) nxt = IDLE;
                else if (start) nxt = DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= IDLE;
            water_level <= 4'd0;
            pump_speed  <= 2'd1;
            pump_on     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alarm       <= 1'b0;
            cnt         <= '0;
        end else begin
            cur         <= nxt;
            water_level <= nxt_level;
            pump_speed  <= speed_step ? (pump_speed == 2'd3 ? 2'd1 : pump_speed + 2'd1) : pump_speed;
            pump_on     <= nxt == DRAIN;
            busy        <= nxt == DRAIN || nxt == PAUSE;
            done        <= nxt == DONE;
            alarm       <= nxt_level >= ALARM_LEVEL;
            cnt         <= (nxt == DRAIN && cur != DRAIN) || tick ? '0 : cur == DRAIN ? cnt + CW'(1) : cnt;
        end
    end
endmodule

// File: tb/tb_pump_drain_controller.sv
// tb_pump_drain_controller: table-driven vectors plus hand sequences for drain, pause, abort and reset.
module tb_pump_drain_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, abort = 1'b0, speed_step = 1'b0;
    logic [3:0] level_in = 4'd0;
    logic [3:0] water_level;
    logic [1:0] pump_speed, state;
    logic       pump_on, busy, done, alarm;
    int         checks = 0, errors = 0;
    string      tag = "reset";

    typedef struct packed {
        logic       s, a, sp;
        logic [3:0] li;
        logic [1:0] st;
        logic [3:0] lvl;
        logic [1:0] spd;
    } vec_t;
    vec_t tbl[26];

    pump_drain_controller #(.TICK_DIV(4), .SAFE_LEVEL(4'd6), .ALARM_LEVEL(4'd9)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .speed_step(speed_step),
        .level_in(level_in), .water_level(water_level), .pump_speed(pump_speed),
        .pump_on(pump_on), .busy(busy), .done(done), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Status bits follow from state and level: pump only in DRAIN, busy in DRAIN/PAUSE, done in DONE.
    function automatic logic [11:0] ex(input logic [1:0] st, input logic [3:0] lvl, input logic [1:0] spd);
        return {st, lvl, spd, st == 2'd1, st == 2'd1 || st == 2'd2, st == 2'd3, lvl >= 4'd9};
    endfunction

    task automatic chk(input logic [11:0] exp);
        logic [11:0] got;
        got = {state, water_level, pump_speed, pump_on, busy, done, alarm};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got st/lvl/spd/on/busy/done/alarm=%h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic s, a, sp, input logic [3:0] li,
                       input logic [1:0] st, input logic [3:0] lvl, input logic [1:0] spd);
        start = s; abort = a; speed_step = sp; level_in = li;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; speed_step = 1'b0;
        chk(ex(st, lvl, spd));
    endtask

    task automatic idle_n(input int n, input logic [1:0] st, input logic [3:0] lvl, input logic [1:0] spd);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0, st, lvl, spd);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 1, 4'd0,  2'd0, 4'd0,  2'd2};
        tbl[1]  = '{0, 0, 1, 4'd0,  2'd0, 4'd0,  2'd3};
        tbl[2]  = '{0, 0, 1, 4'd0,  2'd0, 4'd0,  2'd1};
        tbl[3]  = '{0, 0, 1, 4'd0,  2'd0, 4'd0,  2'd2};
        tbl[4]  = '{0, 0, 1, 4'd0,  2'd0, 4'd0,  2'd3};
        tbl[5]  = '{1, 0, 0, 4'd12, 2'd1, 4'd12, 2'd3};
        tbl[6]  = '{0, 0, 0, 4'd0,  2'd1, 4'd12, 2'd3};
        tbl[7]  = '{0, 0, 0, 4'd0,  2'd1, 4'd12, 2'd3};
        tbl[8]  = '{0, 0, 0, 4'd0,  2'd1, 4'd12, 2'd3};
        tbl[9]  = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[10] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[11] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[12] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[13] = '{0, 0, 0, 4'd0,  2'd3, 4'd6,  2'd3};
        tbl[14] = '{1, 1, 0, 4'd15, 2'd0, 4'd6,  2'd3};
        tbl[15] = '{0, 1, 0, 4'd3,  2'd0, 4'd6,  2'd3};
        tbl[16] = '{1, 0, 0, 4'd5,  2'd3, 4'd5,  2'd3};
        tbl[17] = '{0, 0, 0, 4'd0,  2'd0, 4'd5,  2'd3};
        tbl[18] = '{1, 0, 0, 4'd6,  2'd3, 4'd6,  2'd3};
        tbl[19] = '{0, 0, 0, 4'd0,  2'd0, 4'd6,  2'd3};
        tbl[20] = '{1, 0, 0, 4'd9,  2'd1, 4'd9,  2'd3};
        tbl[21] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[22] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[23] = '{0, 0, 0, 4'd0,  2'd1, 4'd9,  2'd3};
        tbl[24] = '{0, 0, 0, 4'd0,  2'd3, 4'd6,  2'd3};
        tbl[25] = '{0, 0, 0, 4'd0,  2'd0, 4'd6,  2'd3};

        repeat (2) @(posedge clk);
        #1 chk(ex(2'd0, 4'd0, 2'd1));
        @(negedge clk) rst = 1'b1;

        tag = "table";
        foreach (tbl[i]) cyc(tbl[i].s, tbl[i].a, tbl[i].sp, tbl[i].li, tbl[i].st, tbl[i].lvl, tbl[i].spd);

        tag = "drain15_speed1";
        cyc(0, 0, 1, 4'd0, 2'd0, 4'd6, 2'd1);
        cyc(1, 0, 0, 4'd15, 2'd1, 4'd15, 2'd1);
        for (int l = 14; l >= 6; l--) begin
            idle_n(3, 2'd1, 4'(l + 1), 2'd1);
            cyc(0, 0, 0, 4'd0, l == 6 ? 2'd3 : 2'd1, 4'(l), 2'd1);
        end
        cyc(0, 0, 0, 4'd0, 2'd0, 4'd6, 2'd1);

        tag = "pause_resume";
        cyc(1, 0, 0, 4'd13, 2'd1, 4'd13, 2'd1);
        idle_n(3, 2'd1, 4'd13, 2'd1);
        cyc(0, 0, 0, 4'd0, 2'd1, 4'd12, 2'd1);
        idle_n(3, 2'd1, 4'd12, 2'd1);
        cyc(0, 0, 0, 4'd0, 2'd1, 4'd11, 2'd1);
        cyc(1, 0, 0, 4'd0, 2'd2, 4'd11, 2'd1);
        idle_n(20, 2'd2, 4'd11, 2'd1);
        cyc(1, 0, 0, 4'd0, 2'd1, 4'd11, 2'd1);
        idle_n(3, 2'd1, 4'd11, 2'd1);
        cyc(0, 0, 0, 4'd0, 2'd1, 4'd10, 2'd1);
        cyc(1, 0, 0, 4'd0, 2'd2, 4'd10, 2'd1);
        tag = "abort_in_pause";
        cyc(0, 1, 0, 4'd0, 2'd0, 4'd10, 2'd1);

        tag = "tick_with_speed_step";
        cyc(1, 0, 0, 4'd15, 2'd1, 4'd15, 2'd1);
        idle_n(3, 2'd1, 4'd15, 2'd1);
        cyc(0, 0, 1, 4'd0, 2'd1, 4'd14, 2'd2);
        idle_n(3, 2'd1, 4'd14, 2'd2);
        cyc(0, 0, 0, 4'd0, 2'd1, 4'd12, 2'd2);
        tag = "abort_and_start";
        cyc(1, 1, 0, 4'd0, 2'd0, 4'd12, 2'd2);

        tag = "reset_mid_drain";
        cyc(1, 0, 0, 4'd14, 2'd1, 4'd14, 2'd2);
        idle_n(2, 2'd1, 4'd14, 2'd2);
        #2 rst = 1'b0;
        #1 chk(ex(2'd0, 4'd0, 2'd1));
        @(posedge clk); #1 chk(ex(2'd0, 4'd0, 2'd1));
        @(negedge clk) rst = 1'b1;
        tag = "after_reset";
        cyc(1, 0, 0, 4'd8, 2'd1, 4'd8, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
